// File: rtl/piso_serializer_if.sv
// Parallel-word handshake plus the serial frame outputs of the serializer.
// slave is the serializer side; master is the word source / frame consumer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: takes a word over valid/ready and emits it one
// bit per clock, optionally followed by an even-parity bit, with frame strobes.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    piso_serializer_if.slave bus
);
    localparam int N  = WIDTH + (PARITY_EN ? 1 : 0);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic             par_q, par_nxt;
    logic             dout_q, dout_nxt;
    logic             vld_q, vld_nxt;
    logic             fs_q, fs_nxt;
    logic             fe_q, fe_nxt;
    logic             last, ready, accept;

    // The only legal overlap is accepting a new word while the last bit is out.
    assign last   = (state == SHIFT) && (cnt == LAST);
    assign ready  = !clr && ((state == IDLE) || last);
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // shreg holds the bits not yet on dout, next one at the shift-out end.
    always_comb begin
        cnt_nxt   = '0;
        shreg_nxt = shreg;
        par_nxt   = par_q;
        dout_nxt  = 1'b0;
        vld_nxt   = 1'b0;
        fs_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        if (accept) begin
            dout_nxt  = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
            shreg_nxt = MSB_FIRST ? (bus.in_data << 1) : (bus.in_data >> 1);
            par_nxt   = PARITY_EN ? ^bus.in_data : 1'b0;
            vld_nxt   = 1'b1;
            fs_nxt    = 1'b1;
            fe_nxt    = (N == 1);
        end else if (state == SHIFT && !last) begin
            cnt_nxt = cnt + 1'b1;
            vld_nxt = 1'b1;
            fe_nxt  = (cnt_nxt == LAST);
            if (int'(cnt) + 1 < WIDTH) begin
                dout_nxt  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            end else begin
                dout_nxt = par_q;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt    <= '0;
            shreg  <= '0;
            par_q  <= 1'b0;
            dout_q <= 1'b0;
            vld_q  <= 1'b0;
            fs_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            shreg  <= shreg_nxt;
            par_q  <= par_nxt;
            dout_q <= dout_nxt;
            vld_q  <= vld_nxt;
            fs_q   <= fs_nxt;
            fe_q   <= fe_nxt;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = vld_q;
    assign bus.frame_start = fs_q;
    assign bus.frame_end   = fe_q;
    assign bus.busy        = vld_q;
endmodule
